// File: rtl/branch_resolve_unit.sv
// Resolves RV64 conditional branches and trains a BHT of 2-bit saturating counters.
// Defining BRANCH_STATS_EN adds saturating branch/mispredict counter outputs.
module branch_resolve_unit #(
  parameter int XLEN        = 64,
  parameter int PC_W        = 64,
  parameter int BHT_ENTRIES = 16
`ifdef BRANCH_STATS_EN
  ,
  parameter int STAT_W      = 32
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pred_pc,
  output logic            pred_taken,
  input  logic            branch,
  input  logic            flush,
  input  logic [PC_W-1:0] br_pc,
  input  logic [2:0]      funct,
  input  logic [XLEN-1:0] ReadData1,
  input  logic [XLEN-1:0] ReadData2,
  input  logic            predicted_taken,
  output logic            resolve_valid,
  output logic            switch_branch,
  output logic            mispredict,
  output logic            illegal_funct
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bhtNext_d;
  logic [IDX_W-1:0] predIdx;
  logic [IDX_W-1:0] brIdx;
  logic             isEqual;
  logic             lessSigned;
  logic             lessUnsigned;
  logic             taken;
  logic             legal;
  logic             fire;
  logic             train;
  logic             resolveValid_q, switchBranch_q, mispredict_q, illegalFunct_q;
  logic             resolveValid_d, switchBranch_d, mispredict_d, illegalFunct_d;
  logic             unusedPcBits;

  assign predIdx = pred_pc[IDX_W+1:2];
  assign brIdx   = br_pc[IDX_W+1:2];
  assign unusedPcBits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0],
                          br_pc[PC_W-1:IDX_W+2], br_pc[1:0]};

  // Reads the registered counter, so a same-index update this cycle is not yet visible.
  assign pred_taken = bht_q[predIdx][1];

  always_comb begin
    isEqual      = (ReadData1 == ReadData2);
    lessSigned   = ($signed(ReadData1) < $signed(ReadData2));
    lessUnsigned = (ReadData1 < ReadData2);
    taken        = 1'b0;
    legal        = 1'b1;
    case (funct)
      3'b000:  taken = isEqual;
      3'b001:  taken = !isEqual;
      3'b100:  taken = lessSigned;
      3'b101:  taken = !lessSigned;
      3'b110:  taken = lessUnsigned;
      3'b111:  taken = !lessUnsigned;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    fire           = branch && !flush;
    train          = fire && legal;
    resolveValid_d = fire;
    illegalFunct_d = fire && !legal;
    switchBranch_d = train && taken;
    mispredict_d   = train && (taken != predicted_taken);
    bhtNext_d      = bht_q[brIdx];
    if (taken && bht_q[brIdx] != 2'b11) begin
      bhtNext_d = bht_q[brIdx] + 2'd1;
    end else if (!taken && bht_q[brIdx] != 2'b00) begin
      bhtNext_d = bht_q[brIdx] - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resolveValid_q <= 1'b0;
      switchBranch_q <= 1'b0;
      mispredict_q   <= 1'b0;
      illegalFunct_q <= 1'b0;
    end else begin
      resolveValid_q <= resolveValid_d;
      switchBranch_q <= switchBranch_d;
      mispredict_q   <= mispredict_d;
      illegalFunct_q <= illegalFunct_d;
    end
  end

  // Counters restart weakly not-taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (train) begin
      bht_q[brIdx] <= bhtNext_d;
    end
  end

  assign resolve_valid = resolveValid_q;
  assign switch_branch = switchBranch_q;
  assign mispredict    = mispredict_q;
  assign illegal_funct = illegalFunct_q;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] branchCount_q;
  logic [STAT_W-1:0] mispredictCount_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branchCount_q     <= '0;
      mispredictCount_q <= '0;
    end else if (train) begin
      if (branchCount_q != {STAT_W{1'b1}}) begin
        branchCount_q <= branchCount_q + STAT_W'(1);
      end
      if (taken != predicted_taken && mispredictCount_q != {STAT_W{1'b1}}) begin
        mispredictCount_q <= mispredictCount_q + STAT_W'(1);
      end
    end
  end

  assign branch_count     = branchCount_q;
  assign mispredict_count = mispredictCount_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit; a reference BHT model predicts every outcome.
// Stats checks run only when BRANCH_STATS_EN is defined (counters built with STAT_W=2).
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] pred_pc = '0;
  logic        pred_taken;
  logic        branch = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] br_pc = '0;
  logic [2:0]  funct = '0;
  logic [63:0] ReadData1 = '0;
  logic [63:0] ReadData2 = '0;
  logic        predicted_taken = 1'b0;
  logic        resolve_valid, switch_branch, mispredict, illegal_funct;
`ifdef BRANCH_STATS_EN
  logic [1:0]  branch_count, mispredict_count;
  int          modelBc, modelMc;
`endif

  typedef struct packed {
    logic rv, sw, mp, il, predPre, predPost;
  } exp_t;

  typedef struct {
    logic [2:0]  f;
    logic [63:0] a, b;
    logic        t;
  } vec_t;

  exp_t       expQ[$];
  logic [1:0] modelBht [16];
  logic       obsPredPre;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .XLEN(64), .PC_W(64), .BHT_ENTRIES(16)
`ifdef BRANCH_STATS_EN
    , .STAT_W(2)
`endif
  ) dut (
    .clk(clk), .reset(reset), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .branch(branch), .flush(flush), .br_pc(br_pc), .funct(funct),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .predicted_taken(predicted_taken),
    .resolve_valid(resolve_valid), .switch_branch(switch_branch),
    .mispredict(mispredict), .illegal_funct(illegal_funct)
`ifdef BRANCH_STATS_EN
    , .branch_count(branch_count), .mispredict_count(mispredict_count)
`endif
  );

  task automatic resetModel();
    for (int i = 0; i < 16; i++) modelBht[i] = 2'b01;
`ifdef BRANCH_STATS_EN
    modelBc = 0;
    modelMc = 0;
`endif
    expQ.delete();
  endtask

  // Drives one EX-stage cycle, pushes the expected outcome, returns #1 after the edge.
  task automatic applyStimulus(input logic br, input logic fl, input logic [2:0] f,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] pc, input logic pt, input logic expTaken);
    exp_t       e;
    logic [3:0] idx;
    logic       fire, legal;
    @(negedge clk);
    branch = br; flush = fl; funct = f; ReadData1 = a; ReadData2 = b;
    br_pc = pc; pred_pc = pc; predicted_taken = pt;
    idx   = pc[5:2];
    fire  = br && !fl;
    legal = (f != 3'b010) && (f != 3'b011);
    e.predPre = modelBht[idx][1];
    e.rv = fire;
    e.il = fire && !legal;
    e.sw = fire && legal && expTaken;
    e.mp = fire && legal && (expTaken != pt);
    if (fire && legal) begin
      if (expTaken && modelBht[idx] != 2'b11) modelBht[idx] = modelBht[idx] + 2'd1;
      else if (!expTaken && modelBht[idx] != 2'b00) modelBht[idx] = modelBht[idx] - 2'd1;
`ifdef BRANCH_STATS_EN
      if (modelBc < 3) modelBc++;
      if (expTaken != pt && modelMc < 3) modelMc++;
`endif
    end
    e.predPost = modelBht[idx][1];
    expQ.push_back(e);
    #1 obsPredPre = pred_taken;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetModel();
    pred_pc = 64'h40;
    #1;
    vectors += 5;
    if ({resolve_valid, switch_branch, mispredict, illegal_funct} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got %b want 0000",
               {resolve_valid, switch_branch, mispredict, illegal_funct});
    end
    for (int i = 0; i < 16; i++) begin
      pred_pc = 64'(i * 4);
      #1;
      if (i < 4 || i == 15) begin
        if (i < 4) vectors++;
      end
      if (pred_taken !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_bht[%0d] got %b want 0", i, pred_taken);
      end
    end
    vectors += 11;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_compare();
    vec_t tbl[12];
    exp_t e;
    tbl[0]  = '{3'b000, 64'd5, 64'd5, 1'b1};
    tbl[1]  = '{3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1};
    tbl[2]  = '{3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0};
    tbl[3]  = '{3'b101, 64'd7, 64'd7, 1'b1};
    tbl[4]  = '{3'b111, 64'd7, 64'd7, 1'b1};
    tbl[5]  = '{3'b001, 64'd3, 64'd3, 1'b0};
    tbl[6]  = '{3'b001, 64'd3, 64'd4, 1'b1};
    tbl[7]  = '{3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0};
    tbl[8]  = '{3'b111, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tbl[9]  = '{3'b000, 64'h8000_0000_0000_0000, 64'd0, 1'b0};
    tbl[10] = '{3'b100, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tbl[11] = '{3'b110, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b0, tbl[i].f, tbl[i].a, tbl[i].b,
                    (i == 0) ? 64'h40 : 64'(32'h100 + i * 4), i[0], tbl[i].t);
      e = expQ.pop_front();
      vectors += 6;
      if ({resolve_valid, switch_branch, mispredict, illegal_funct} !== {e.rv, e.sw, e.mp, e.il}) begin
        miscompares++;
        $display("[TB] FAIL compare[%0d] rv/sw/mp/il got %b want %b", i,
                 {resolve_valid, switch_branch, mispredict, illegal_funct}, {e.rv, e.sw, e.mp, e.il});
      end
      if (obsPredPre !== e.predPre) begin
        miscompares++;
        $display("[TB] FAIL compare_pred_pre[%0d] got %b want %b", i, obsPredPre, e.predPre);
      end
      if (pred_taken !== e.predPost) begin
        miscompares++;
        $display("[TB] FAIL compare_pred_post[%0d] got %b want %b", i, pred_taken, e.predPost);
      end
      vectors -= 3;
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, (i < 5) ? 3'b000 : 3'b001, 64'd0, 64'd0,
                    64'h80, 1'b1, i < 5);
      e = expQ.pop_front();
      vectors += 3;
      if ({resolve_valid, switch_branch, mispredict, illegal_funct} !== {e.rv, e.sw, e.mp, e.il}) begin
        miscompares++;
        $display("[TB] FAIL saturate[%0d] rv/sw/mp/il got %b want %b", i,
                 {resolve_valid, switch_branch, mispredict, illegal_funct}, {e.rv, e.sw, e.mp, e.il});
      end
      if (obsPredPre !== e.predPre) begin
        miscompares++;
        $display("[TB] FAIL saturate_collision[%0d] got %b want %b", i, obsPredPre, e.predPre);
      end
      if (pred_taken !== e.predPost) begin
        miscompares++;
        $display("[TB] FAIL saturate_pred[%0d] got %b want %b", i, pred_taken, e.predPost);
      end
    end
  endtask

  task automatic test_flush_illegal();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: applyStimulus(1'b1, 1'b1, 3'b000, 64'd9, 64'd9, 64'h48, 1'b0, 1'b1);
        1: applyStimulus(1'b1, 1'b0, 3'b010, 64'd9, 64'd9, 64'h48, 1'b0, 1'b0);
        2: applyStimulus(1'b1, 1'b0, 3'b011, 64'd1, 64'd2, 64'h48, 1'b1, 1'b0);
        default: applyStimulus(1'b0, 1'b0, 3'b000, 64'd9, 64'd9, 64'h48, 1'b0, 1'b1);
      endcase
      e = expQ.pop_front();
      vectors += 3;
      if ({resolve_valid, switch_branch, mispredict, illegal_funct} !== {e.rv, e.sw, e.mp, e.il}) begin
        miscompares++;
        $display("[TB] FAIL flush_illegal[%0d] rv/sw/mp/il got %b want %b", i,
                 {resolve_valid, switch_branch, mispredict, illegal_funct}, {e.rv, e.sw, e.mp, e.il});
      end
      if (obsPredPre !== e.predPre) begin
        miscompares++;
        $display("[TB] FAIL flush_illegal_pre[%0d] got %b want %b", i, obsPredPre, e.predPre);
      end
      if (pred_taken !== e.predPost) begin
        miscompares++;
        $display("[TB] FAIL flush_illegal_bht[%0d] got %b want %b", i, pred_taken, e.predPost);
      end
    end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    reset = 1'b1;
    resetModel();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 3'b001, 64'd3, 64'd4, 64'h60, 1'b0, 1'b1);
      void'(expQ.pop_front());
      vectors += 2;
      if (branch_count !== 2'(modelBc)) begin
        miscompares++;
        $display("[TB] FAIL stats_branch[%0d] got %0d want %0d", i, branch_count, modelBc);
      end
      if (mispredict_count !== 2'(modelMc)) begin
        miscompares++;
        $display("[TB] FAIL stats_mispredict[%0d] got %0d want %0d", i, mispredict_count, modelMc);
      end
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({branch_count, mispredict_count} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL stats_reset got %b want 0000", {branch_count, mispredict_count});
    end
    resetModel();
    @(negedge clk);
    reset = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 3'b000, 64'd1, 64'd1, 64'h44, 1'b1, 1'b1);
      e = expQ.pop_front();
      vectors++;
      if (pred_taken !== e.predPost) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_train[%0d] got %b want %b", i, pred_taken, e.predPost);
      end
    end
    @(negedge clk);
    branch = 1'b1; flush = 1'b0; funct = 3'b000; br_pc = 64'h44;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({resolve_valid, switch_branch, mispredict, illegal_funct} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_async got %b want 0000",
               {resolve_valid, switch_branch, mispredict, illegal_funct});
    end
    resetModel();
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      pred_pc = 64'(i * 4);
      #1;
      vectors++;
      if (pred_taken !== modelBht[i][1]) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_bht[%0d] got %b want %b", i, pred_taken, modelBht[i][1]);
      end
    end
    vectors++;
    if (resolve_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_discard got %b want 0", resolve_valid);
    end
    @(negedge clk);
    branch = 1'b0;
    reset  = 1'b0;
  endtask

  initial begin
    $display("[TB] starting branch_resolve_unit bench");
    test_reset();
    test_compare();
    test_saturate();
    test_flush_illegal();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
